// File: rtl/ntsc_write_if.sv
// ntsc_write_if: groups the decoder pixel stream, the memory-side
// flag/done handshake and the status outputs of ntsc_write.
//   frame_start, pix_valid, pix_data : pixel stream from the NTSC decoder
//   frame_flag, done_ntsc            : memory interface buffer swap / acknowledge
//   ntsc_flag, ntsc_pixel            : write request and FIFO head word
//   overflow, drop_count, fifo_count : drop status and FIFO occupancy
// master drives the stream and handshake inputs; slave is the writer itself.
interface ntsc_write_if #(
  parameter int LOG_TRUNC = 18,
  parameter int LOG_MEM   = 36,
  parameter int LOG_DEPTH = 2
);
  logic                 frame_start;
  logic                 pix_valid;
  logic [LOG_TRUNC-1:0] pix_data;
  logic                 frame_flag;
  logic                 done_ntsc;
  logic                 ntsc_flag;
  logic [LOG_MEM-1:0]   ntsc_pixel;
  logic                 overflow;
  logic [7:0]           drop_count;
  logic [LOG_DEPTH:0]   fifo_count;

  modport master (
    output frame_start, pix_valid, pix_data, frame_flag, done_ntsc,
    input  ntsc_flag, ntsc_pixel, overflow, drop_count, fifo_count
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, frame_flag, done_ntsc,
    output ntsc_flag, ntsc_pixel, overflow, drop_count, fifo_count
  );
endinterface

// File: rtl/ntsc_write.sv
// ntsc_write: packs consecutive decoder pixels into two-pixel memory words
// (earlier pixel in the upper half), buffers them in a small circular FIFO
// and offers the head word to the memory interface via ntsc_flag/done_ntsc.
// Ports:
//   clock  : system clock, posedge
//   reset  : asynchronous, active-high, clears all state
//   bus    : ntsc_write_if.slave (pixel stream, handshake, status)
// Capture starts only at a frame_start; a frame_start while capturing
// re-aligns pairing and clears the drop status but keeps buffered words.
module ntsc_write #(
  parameter int LOG_TRUNC = 18,
  parameter int LOG_MEM   = 36,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  ntsc_write_if.slave   bus
);

  localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH+1)'(DEPTH);

  typedef enum logic {SYNCING, CAPTURING} state_t;

  state_t state, next_state;
  logic   accept;   // pixel is consumed this cycle
  logic   restart;  // consumed pixel starts a new pair (frame alignment)

  logic                 half_valid;
  logic [LOG_TRUNC-1:0] held;

  logic [LOG_MEM-1:0]   mem [DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [LOG_DEPTH:0]   count;

  logic push, pop, push_ok, drop;

  // ---------------- FSM: state register ----------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SYNCING;
    else       state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    if (state == SYNCING && bus.pix_valid && bus.frame_start)
      next_state = CAPTURING;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept  = 1'b0;
    restart = 1'b0;
    case (state)
      SYNCING: begin
        accept  = bus.pix_valid && bus.frame_start;
        restart = bus.pix_valid && bus.frame_start;
      end
      CAPTURING: begin
        accept  = bus.pix_valid;
        restart = bus.pix_valid && bus.frame_start;
      end
      default: begin
        accept  = 1'b0;
        restart = 1'b0;
      end
    endcase
  end

  // A word completes on the second pixel of a pair; a restart pixel always
  // opens a fresh pair, discarding any stale first half.
  assign push    = accept && !restart && half_valid;
  assign pop     = bus.done_ntsc && (count != '0);
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok = push && ((count != FULL) || pop);
  assign drop    = push && !push_ok;

  // ---------------- pixel pairing ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_valid <= 1'b0;
      held       <= '0;
    end else if (accept) begin
      if (restart || !half_valid) begin
        held       <= bus.pix_data;
        half_valid <= 1'b1;
      end else begin
        half_valid <= 1'b0;
      end
    end
  end

  // ---------------- FIFO ----------------
  // NOTE: storage is not reset; occupancy is tracked by count and the
  // read port is forced to zero when empty, so stale contents never leak.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {held, bus.pix_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  // ---------------- drop status ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else if (restart) begin
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else if (drop) begin
      bus.overflow <= 1'b1;
      if (bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 8'd1;
    end
  end

  // ---------------- memory-side outputs ----------------
  assign bus.ntsc_flag  = !reset && !bus.frame_flag && (count != '0);
  assign bus.ntsc_pixel = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_ntsc_write.sv
// tb_ntsc_write: directed bench for ntsc_write. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_ntsc_write;
  localparam int LT = 18;
  localparam int LM = 36;
  localparam int LD = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ntsc_write_if #(.LOG_TRUNC(LT), .LOG_MEM(LM), .LOG_DEPTH(LD)) bus ();

  ntsc_write #(.LOG_TRUNC(LT), .LOG_MEM(LM), .DEPTH(4), .LOG_DEPTH(LD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Distinct, easily recognisable pixel values.
  function automatic logic [LT-1:0] px(input int i);
    return LT'(32'h00101 * (i + 1));
  endfunction

  function automatic logic [LM-1:0] wd(input int i);
    return {px(i), px(i + 1)};
  endfunction

  // Apply one cycle of stimulus and advance to the next falling edge.
  task automatic step(input logic fs, input logic pv, input logic [LT-1:0] d, input logic dn);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = d;
    bus.done_ntsc   = dn;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.frame_flag = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0);
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL reset_flag: got %b want 0", bus.ntsc_flag); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    tests++; if (bus.ntsc_pixel !== 36'd0) begin fails++; $display("FAIL reset_pixel: got %h want 0", bus.ntsc_pixel); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    tests++; if (bus.drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, px(i), 1'b0);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL sync_count: got %0d want 0", bus.fifo_count); end
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL sync_flag: got %b want 0", bus.ntsc_flag); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_basic_pair;
    step(1'b1, 1'b1, 18'h3F000, 1'b0);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL pair_half_count: got %0d want 0", bus.fifo_count); end
    step(1'b0, 1'b1, 18'h00FFF, 1'b0);
    tests++; if (bus.ntsc_flag !== 1'b1) begin fails++; $display("FAIL pair_flag_rise: got %b want 1", bus.ntsc_flag); end
    tests++; if (bus.ntsc_pixel !== {18'h3F000, 18'h00FFF}) begin fails++; $display("FAIL pair_word: got %h want %h", bus.ntsc_pixel, {18'h3F000, 18'h00FFF}); end
    tests++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL pair_count: got %0d want 1", bus.fifo_count); end
    step(1'b0, 1'b0, '0, 1'b1);
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL pair_flag_fall: got %b want 0", bus.ntsc_flag); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL pair_drain: got %0d want 0", bus.fifo_count); end
    tests++; if (bus.ntsc_pixel !== 36'd0) begin fails++; $display("FAIL pair_empty_pixel: got %h want 0", bus.ntsc_pixel); end
    step(1'b0, 1'b0, '0, 1'b1);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL empty_pop: got %0d want 0", bus.fifo_count); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 1'b1, px(i), 1'b0);
      if (i == 7) begin
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
        tests++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_full: got %0d want 4", bus.fifo_count); end
      end
    end
    tests++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    tests++; if (bus.drop_count !== 8'd1) begin fails++; $display("FAIL ovf_drop: got %0d want 1", bus.drop_count); end
    tests++; if (bus.ntsc_pixel !== wd(0)) begin fails++; $display("FAIL ovf_head: got %h want %h", bus.ntsc_pixel, wd(0)); end
    tests++; if (bus.ntsc_flag !== 1'b1) begin fails++; $display("FAIL ovf_req: got %b want 1", bus.ntsc_flag); end
  endtask

  task automatic test_full_push_pop;
    int exp_k [4] = '{2, 4, 6, 10};
    step(1'b0, 1'b1, px(10), 1'b0);
    step(1'b0, 1'b1, px(11), 1'b1);
    tests++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL fullpp_count: got %0d want 4", bus.fifo_count); end
    tests++; if (bus.drop_count !== 8'd1) begin fails++; $display("FAIL fullpp_drop: got %0d want 1", bus.drop_count); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (bus.ntsc_pixel !== wd(exp_k[j])) begin
        fails++; $display("FAIL drain_word%0d: got %h want %h", j, bus.ntsc_pixel, wd(exp_k[j]));
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", bus.fifo_count); end
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL drain_flag: got %b want 0", bus.ntsc_flag); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_restart;
    step(1'b0, 1'b1, px(20), 1'b0);
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL rs_sticky: got %b want 1", bus.overflow); end
    step(1'b1, 1'b1, px(21), 1'b0);
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rs_ovf_clear: got %b want 0", bus.overflow); end
    tests++; if (bus.drop_count !== 8'd0) begin fails++; $display("FAIL rs_drop_clear: got %0d want 0", bus.drop_count); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL rs_no_stale: got %0d want 0", bus.fifo_count); end
    step(1'b0, 1'b1, px(22), 1'b0);
    tests++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL rs_count: got %0d want 1", bus.fifo_count); end
    tests++; if (bus.ntsc_pixel !== wd(21)) begin fails++; $display("FAIL rs_word: got %h want %h", bus.ntsc_pixel, wd(21)); end
    step(1'b0, 1'b0, '0, 1'b1);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL rs_drain: got %0d want 0", bus.fifo_count); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_frame_flag;
    bus.frame_flag = 1'b1;
    for (int i = 30; i < 34; i++) step(1'b0, 1'b1, px(i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL ff_masked: got %b want 0", bus.ntsc_flag); end
    tests++; if (bus.fifo_count !== 3'd2) begin fails++; $display("FAIL ff_count: got %0d want 2", bus.fifo_count); end
    bus.frame_flag = 1'b0;
    #1;
    tests++; if (bus.ntsc_flag !== 1'b1) begin fails++; $display("FAIL ff_unmask: got %b want 1", bus.ntsc_flag); end
    tests++; if (bus.ntsc_pixel !== wd(30)) begin fails++; $display("FAIL ff_word0: got %h want %h", bus.ntsc_pixel, wd(30)); end
    step(1'b0, 1'b0, '0, 1'b1);
    tests++; if (bus.ntsc_pixel !== wd(32)) begin fails++; $display("FAIL ff_word1: got %h want %h", bus.ntsc_pixel, wd(32)); end
    tests++; if (bus.ntsc_flag !== 1'b1) begin fails++; $display("FAIL ff_flag1: got %b want 1", bus.ntsc_flag); end
    step(1'b0, 1'b0, '0, 1'b0);
    tests++; if (bus.ntsc_pixel !== wd(32)) begin fails++; $display("FAIL ff_hold: got %h want %h", bus.ntsc_pixel, wd(32)); end
    step(1'b0, 1'b0, '0, 1'b1);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL ff_drain: got %0d want 0", bus.fifo_count); end
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL ff_flag_end: got %b want 0", bus.ntsc_flag); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b1, px(40), 1'b0);
    step(1'b0, 1'b1, px(41), 1'b0);
    step(1'b0, 1'b1, px(42), 1'b0);
    tests++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL mid_count: got %0d want 1", bus.fifo_count); end
    bus.pix_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.ntsc_flag !== 1'b0) begin fails++; $display("FAIL mid_async_flag: got %b want 0", bus.ntsc_flag); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL mid_async_count: got %0d want 0", bus.fifo_count); end
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b1, px(43), 1'b0);
    step(1'b0, 1'b1, px(44), 1'b0);
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL mid_resync: got %0d want 0", bus.fifo_count); end
    step(1'b1, 1'b1, px(45), 1'b0);
    step(1'b0, 1'b1, px(46), 1'b0);
    tests++; if (bus.ntsc_pixel !== wd(45)) begin fails++; $display("FAIL mid_word: got %h want %h", bus.ntsc_pixel, wd(45)); end
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.frame_flag  = 1'b0;
    bus.done_ntsc   = 1'b0;
    @(negedge clock);
    test_reset;
    test_basic_pair;
    test_overflow;
    test_full_push_pop;
    test_restart;
    test_frame_flag;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ntsc_write.md
# ntsc_write

Capture-side writer into the frame-buffer memory interface; it is the counterpart of the VGA fetcher, which reads two-pixel words back out. It accepts a stream of truncated YCbCr pixels from the NTSC decoder and packs consecutive pixel pairs into memory words. It buffers the packed words in a small FIFO and presents them to the memory interface through a flag/done handshake. It also tracks frame alignment and reports overflow when memory falls behind.

## Interface
Parameters:
- LOG_TRUNC, 18: bits per pixel, packed Y[17:12] Cb[11:6] Cr[5:0].
- LOG_MEM, 36: memory word width; must equal 2*LOG_TRUNC.
- DEPTH, 4: FIFO depth in words; power of two.
- LOG_DEPTH, 2: log2(DEPTH).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- frame_start  in  1  one-cycle pulse from decoder marking the first pixel of a frame; coincides with that pixel's pix_valid.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  LOG_TRUNC  incoming pixel.
- frame_flag  in  1  memory interface is swapping buffers; write requests are suppressed while it is high.
- done_ntsc  in  1  one-cycle acknowledge: the memory interface consumed ntsc_pixel this cycle.
- ntsc_flag  out  1  write request; a word is available on ntsc_pixel.
- ntsc_pixel  out  LOG_MEM  FIFO head word.
- overflow  out  1  sticky; a word was dropped since reset or the last frame_start.
- drop_count  out  8  number of dropped words, saturating at 255; cleared like overflow.
- fifo_count  out  LOG_DEPTH+1  current FIFO occupancy (debug).

## Operation
- State machine, two states:
  - SYNCING (reset state): all pixels are ignored. On pix_valid && frame_start, go to CAPTURING; that pixel is consumed as the first pixel of a pair.
  - CAPTURING: every pix_valid pixel is consumed.
- frame_start while in CAPTURING:
  - Any pending half pair is discarded.
  - The accompanying pixel becomes the first half of a new pair.
  - overflow and drop_count clear.
  - FIFO contents are kept.
- Pairing:
  - half_valid register plus a LOG_TRUNC holding register.
  - First pixel goes to the holding register; half_valid <= 1.
  - Second pixel forms the word {held, pix_data]}, with the earlier pixel in the upper half, matching the reader's upper-first unpacking. half_valid <= 0 and the word is pushed.
- FIFO: circular, DEPTH entries, with read pointer, write pointer and a count of width LOG_DEPTH+1.
  - Push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - A rejected push drops the word: overflow <= 1, drop_count increments unless it is already 255.
- Pop: done_ntsc && count != 0 advances the read pointer. done_ntsc with an empty FIFO is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- ntsc_flag = !reset && !frame_flag && count != 0. It is combinational from registered state.
- ntsc_pixel is the FIFO entry at the read pointer. It is 0 when the FIFO is empty.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, immediate):
  - state = SYNCING, half_valid = 0, pointers = 0, count = 0.
  - ntsc_flag = 0, ntsc_pixel = 0, overflow = 0, drop_count = 0, fifo_count = 0.
- Reset asserted mid-frame drops all buffered and pending data. After release, the block waits for the next frame_start.
- Latency:
  - A second pixel sampled at edge N appears on ntsc_pixel after edge N.
  - ntsc_flag rises in the cycle after edge N, provided frame_flag is low.
- Handshake:
  - ntsc_pixel holds stable while ntsc_flag is high and done_ntsc is low.
  - done_ntsc is sampled at the posedge. The next word, if any, is presented in the following cycle with no bubble.
- frame_flag does not stall capture or pairing; it only masks ntsc_flag.
- Sustained throughput: one pixel per cycle in, one word per two cycles out when done_ntsc keeps pace.

## Test plan
- Reset, then pixels without frame_start -> ntsc_flag stays 0 and fifo_count stays 0.
- frame_start with pixel 0x3F000, then pixel 0x00FFF, then done_ntsc held high -> ntsc_pixel = 36'h3F000_00FFF, ntsc_flag high for exactly one cycle, fifo_count returns to 0.
- done_ntsc held low, 10 valid pixels after frame_start -> first 4 words buffered, 1 word dropped, overflow = 1, drop_count = 1, fifo_count = 4.
- FIFO full, and in the same cycle a second pixel completes a pair while done_ntsc is high -> word accepted, count stays 4, drop_count unchanged.
- Odd pixel pending, then frame_start with pixel A and pixel B -> first FIFO word is {A,B}; the stale pixel never appears; overflow clears.
- frame_flag high with 2 words buffered -> ntsc_flag = 0 and words are retained. frame_flag low -> both words delivered in order on consecutive done_ntsc pulses.
